// File: rtl/ecc_fifo_rd_drain_if.sv
// Stream interface carrying corrected FIFO words and their ECC tags.
//   m_valid  word available (driven by the drain)
//   m_ready  sink accepts the word this cycle (driven by the sink)
//   m_data   corrected data word
//   m_sec    word had a single-bit error that was corrected
//   m_ded    word is uncorrectable (double-bit error)
interface ecc_fifo_rd_drain_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sec;
  logic              m_ded;

  modport master (
    output m_valid,
    output m_data,
    output m_sec,
    output m_ded,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_sec,
    input  m_ded,
    output m_ready
  );
endinterface

// File: rtl/ecc_fifo_rd_drain.sv
// Read-side drain for a SECDED-protected FIFO with a fixed-latency read port.
// Issues f_rd_en only when a skid-buffer slot is reserved for the returning word, so the buffer
// can never overflow, and presents the words as a valid/ready stream tagged with sec/ded flags.
// Saturating SEC/DED event counters and a sticky protocol-error flag feed the status block.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable                   1 = keep reading the FIFO; 0 = stop issuing reads, finish in-flight
//   f_empty, f_rd_en         FIFO empty flag and read request
//   f_dout, f_dout_valid     FIFO read data and its valid strobe
//   f_sec_err, f_ded_err     ECC flags, qualified by f_dout_valid
//   m                        output stream (ecc_fifo_rd_drain_if master)
//   sec_cnt, ded_cnt         saturating SEC/DED event counts
//   cnt_clr                  clear both counters (an event in the same cycle counts as 1)
//   proto_err                sticky: read data arrived with no read in flight
//   busy                     FSM not idle or buffer holds data
//
// Build option: define ECC_DED_DROP_EN to discard DED words (counted, never forwarded, m_ded = 0).
module ecc_fifo_rd_drain #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                f_empty,
  output logic                f_rd_en,
  input  logic [DATA_W-1:0]   f_dout,
  input  logic                f_dout_valid,
  input  logic                f_sec_err,
  input  logic                f_ded_err,
  ecc_fifo_rd_drain_if.master m,
  output logic [CNT_W-1:0]    sec_cnt,
  output logic [CNT_W-1:0]    ded_cnt,
  input  logic                cnt_clr,
  output logic                proto_err,
  output logic                busy
);

  localparam int unsigned PTR_W = $clog2(SKID_DEPTH);
  localparam int unsigned INF_W = PTR_W + 1;
  localparam int unsigned SUM_W = INF_W + 1;

  // Full throughput needs at least one slot per word the read pipe can hold.
  if (SKID_DEPTH < 2 || SKID_DEPTH < RD_LATENCY || (SKID_DEPTH & (SKID_DEPTH - 1)) != 0)
  begin : g_bad_cfg
    $error("SKID_DEPTH must be a power of 2, >= 2 and >= RD_LATENCY");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  typedef logic [DATA_W+1:0] entry_t;  // {ded, sec, data}

  state_e             state_q, state_d;
  logic [INF_W-1:0]   inflight_q, inflight_d;
  logic [INF_W-1:0]   occ_q, occ_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  entry_t             mem_q [SKID_DEPTH];
  logic [CNT_W-1:0]   sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;
  logic               proto_q;

  logic [SUM_W-1:0]   credit_used;
  logic               accept, stray, is_sec, is_ded, push, pop;
  entry_t             head;

  always_comb begin
    credit_used = SUM_W'(inflight_q) + SUM_W'(occ_q);
    f_rd_en     = (state_q == StRun) && !f_empty && (credit_used < SUM_W'(SKID_DEPTH));
    accept      = f_dout_valid && (inflight_q != '0);
    stray       = f_dout_valid && (inflight_q == '0);
    // Both flags set means the word is uncorrectable; it is not also reported as corrected.
    is_ded      = f_ded_err;
    is_sec      = f_sec_err && !f_ded_err;
`ifdef ECC_DED_DROP_EN
    push        = accept && !is_ded;
`else
    push        = accept;
`endif
    pop         = (occ_q != '0) && m.m_ready;

    inflight_d = inflight_q;
    case ({f_rd_en, accept})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + INF_W'(1);
      2'b01:   occ_d = occ_q - INF_W'(1);
      default: occ_d = occ_q;
    endcase

    sec_cnt_d = sec_cnt_q;
    if (cnt_clr) begin
      sec_cnt_d = CNT_W'(accept && is_sec);
    end else if (accept && is_sec && (sec_cnt_q != '1)) begin
      sec_cnt_d = sec_cnt_q + CNT_W'(1);
    end

    ded_cnt_d = ded_cnt_q;
    if (cnt_clr) begin
      ded_cnt_d = CNT_W'(accept && is_ded);
    end else if (accept && is_ded && (ded_cnt_q != '1)) begin
      ded_cnt_d = ded_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (inflight_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      inflight_q <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      sec_cnt_q  <= sec_cnt_d;
      ded_cnt_q  <= ded_cnt_d;
      if (stray) proto_q <= 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible unless occupancy says so.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {is_ded, is_sec, f_dout};
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    m.m_valid = (occ_q != '0);
    m.m_data  = m.m_valid ? head[DATA_W-1:0] : '0;
    m.m_sec   = m.m_valid && head[DATA_W];
`ifdef ECC_DED_DROP_EN
    m.m_ded   = 1'b0;
`else
    m.m_ded   = m.m_valid && head[DATA_W+1];
`endif
    sec_cnt   = sec_cnt_q;
    ded_cnt   = ded_cnt_q;
    proto_err = proto_q;
    busy      = (state_q != StIdle) || (occ_q != '0);
  end

endmodule
